// File: rtl/control_unit.sv
// Control unit: program counter, registered instruction ROM, instruction
// register and the Moore FSM that sequences fetch, decode and execute.

// Program counter: clear has priority over increment, and wraps 127 -> 0.
module ProgramCounter (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_clr,
    input  logic       i_up,
    output logic [6:0] o_pc
);
    logic [6:0] r_pc;

    // Clear wins over increment; the 7-bit add wraps naturally at 127.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_pc <= '0;
        else if (i_clr)
            r_pc <= '0;
        else if (i_up)
            r_pc <= r_pc + 7'd1;
    end

    assign o_pc = r_pc;
endmodule

// Instruction register: loads on i_ld, otherwise holds.
module InstructionRegister (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_ld,
    input  logic [15:0] i_d,
    output logic [15:0] o_q
);
    logic [15:0] r_q;

    // Capture the ROM word only when the FSM asks for it.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_q <= '0;
        else if (i_ld)
            r_q <= i_d;
    end

    assign o_q = r_q;
endmodule

// 128 x 16 instruction ROM with a registered read port (1-cycle latency).
module InstructionRom (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [6:0]  i_addr,
    output logic [15:0] o_data
);
    logic [15:0] w_word;
    logic [15:0] r_data;

    // Fixed program image; every address past the program reads as NOOP.
    always_comb begin
        case (i_addr)
            7'd0:    w_word = 16'h20B1;
            7'd1:    w_word = 16'h21B2;
            7'd2:    w_word = 16'h2063;
            7'd3:    w_word = 16'h28A4;
            7'd4:    w_word = 16'h4145;
            7'd5:    w_word = 16'h4326;
            7'd6:    w_word = 16'h3560;
            7'd7:    w_word = 16'h1CD0;
            7'd8:    w_word = 16'h5000;
            default: w_word = 16'h0000;
        endcase
    end

    // Registered read so the word appears one edge after the address.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_data <= '0;
        else
            r_data <= w_word;
    end

    assign o_data = r_data;
endmodule

module control_unit (
    input  logic        clk,
    input  logic        reset,
    output logic [3:0]  OutState,
    output logic [3:0]  NextState,
    output logic [7:0]  D_addr,
    output logic        D_wr,
    output logic        RF_s,
    output logic        RF_W_en,
    output logic [3:0]  RF_Ra_addr,
    output logic [3:0]  RF_Rb_addr,
    output logic [3:0]  RF_W_addr,
    output logic [2:0]  ALU_s0,
    output logic [6:0]  PC_Out,
    output logic        PC_clr,
    output logic        PC_up,
    output logic        IR_ld,
    output logic [15:0] IR_Out,
    output logic [15:0] data
);
    typedef enum logic [3:0] {
        StInit   = 4'd0,
        StFetch  = 4'd1,
        StDecode = 4'd2,
        StNoop   = 4'd3,
        StLoadA  = 4'd4,
        StLoadB  = 4'd5,
        StStore  = 4'd6,
        StAdd    = 4'd7,
        StSub    = 4'd8,
        StHalt   = 4'd9
    } stateT;

    stateT       r_state;
    stateT       w_nextState;
    logic [6:0]  w_pc;
    logic [15:0] w_romData;
    logic [15:0] w_ir;
    logic [7:0]  r_dAddr;
    logic        r_dWr;
    logic        r_rfS;
    logic        r_rfWEn;
    logic [3:0]  r_raAddr;
    logic [3:0]  r_rbAddr;
    logic [3:0]  r_wAddr;
    logic [2:0]  r_aluS0;
    logic        r_pcClr;
    logic        r_pcUp;
    logic        r_irLd;

    ProgramCounter u_pc (
        .i_clk   (clk),
        .i_reset (reset),
        .i_clr   (r_pcClr),
        .i_up    (r_pcUp),
        .o_pc    (w_pc)
    );

    InstructionRom u_rom (
        .i_clk   (clk),
        .i_reset (reset),
        .i_addr  (w_pc),
        .o_data  (w_romData)
    );

    InstructionRegister u_ir (
        .i_clk   (clk),
        .i_reset (reset),
        .i_ld    (r_irLd),
        .i_d     (w_romData),
        .o_q     (w_ir)
    );

    // Next-state logic: Decode branches on the opcode, unknown opcodes run as NOOP.
    always_comb begin
        w_nextState = StInit;
        case (r_state)
            StInit:   w_nextState = StFetch;
            StFetch:  w_nextState = StDecode;
            StDecode: begin
                case (w_ir[15:12])
                    4'b0001: w_nextState = StStore;
                    4'b0010: w_nextState = StLoadA;
                    4'b0011: w_nextState = StAdd;
                    4'b0100: w_nextState = StSub;
                    4'b0101: w_nextState = StHalt;
                    default: w_nextState = StNoop;
                endcase
            end
            StLoadA:  w_nextState = StLoadB;
            StNoop,
            StLoadB,
            StStore,
            StAdd,
            StSub:    w_nextState = StFetch;
            StHalt:   w_nextState = StHalt;
            default:  w_nextState = StInit;
        endcase
    end

    // State register plus outputs registered from the state being entered;
    // IR is stable from Decode onward, so execute-state fields decode cleanly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= StInit;
            r_dAddr  <= '0;
            r_dWr    <= 1'b0;
            r_rfS    <= 1'b0;
            r_rfWEn  <= 1'b0;
            r_raAddr <= '0;
            r_rbAddr <= '0;
            r_wAddr  <= '0;
            r_aluS0  <= '0;
            r_pcClr  <= 1'b1;
            r_pcUp   <= 1'b0;
            r_irLd   <= 1'b0;
        end else begin
            r_state  <= w_nextState;
            r_dAddr  <= '0;
            r_dWr    <= 1'b0;
            r_rfS    <= 1'b0;
            r_rfWEn  <= 1'b0;
            r_raAddr <= '0;
            r_rbAddr <= '0;
            r_wAddr  <= '0;
            r_aluS0  <= '0;
            r_pcClr  <= 1'b0;
            r_pcUp   <= 1'b0;
            r_irLd   <= 1'b0;
            case (w_nextState)
                StInit:  r_pcClr <= 1'b1;
                StFetch: begin
                    r_irLd <= 1'b1;
                    r_pcUp <= 1'b1;
                end
                StLoadA: begin
                    r_dAddr <= w_ir[11:4];
                    r_wAddr <= w_ir[3:0];
                    r_rfS   <= 1'b1;
                end
                StLoadB: begin
                    r_dAddr <= w_ir[11:4];
                    r_wAddr <= w_ir[3:0];
                    r_rfS   <= 1'b1;
                    r_rfWEn <= 1'b1;
                end
                StStore: begin
                    r_dAddr  <= w_ir[11:4];
                    r_raAddr <= w_ir[3:0];
                    r_dWr    <= 1'b1;
                end
                StAdd: begin
                    r_raAddr <= w_ir[11:8];
                    r_rbAddr <= w_ir[7:4];
                    r_wAddr  <= w_ir[3:0];
                    r_aluS0  <= 3'b001;
                    r_rfWEn  <= 1'b1;
                end
                StSub: begin
                    r_raAddr <= w_ir[11:8];
                    r_rbAddr <= w_ir[7:4];
                    r_wAddr  <= w_ir[3:0];
                    r_aluS0  <= 3'b010;
                    r_rfWEn  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign OutState   = r_state;
    assign NextState  = w_nextState;
    assign D_addr     = r_dAddr;
    assign D_wr       = r_dWr;
    assign RF_s       = r_rfS;
    assign RF_W_en    = r_rfWEn;
    assign RF_Ra_addr = r_raAddr;
    assign RF_Rb_addr = r_rbAddr;
    assign RF_W_addr  = r_wAddr;
    assign ALU_s0     = r_aluS0;
    assign PC_Out     = w_pc;
    assign PC_clr     = r_pcClr;
    assign PC_up      = r_pcUp;
    assign IR_ld      = r_irLd;
    assign IR_Out     = w_ir;
    assign data       = w_romData;
endmodule

// File: tb/tb_control_unit.sv
// Testbench for control_unit: an instruction-level model fills a queue of
// expected per-cycle outputs, which is drained one entry per cycle.
module tb_control_unit;

    typedef struct packed {
        logic [3:0]  st;
        logic [3:0]  nx;
        logic [6:0]  pc;
        logic [15:0] ir;
        logic [15:0] dat;
        logic [7:0]  dAddr;
        logic        dWr;
        logic        rfS;
        logic        rfWEn;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [3:0]  wa;
        logic [2:0]  alu;
        logic        pcClr;
        logic        pcUp;
        logic        irLd;
    } CycleRec;

    logic        clk;
    logic        reset;
    logic [3:0]  outState;
    logic [3:0]  nextState;
    logic [7:0]  dAddr;
    logic        dWr;
    logic        rfS;
    logic        rfWEn;
    logic [3:0]  raAddr;
    logic [3:0]  rbAddr;
    logic [3:0]  wAddr;
    logic [2:0]  aluS0;
    logic [6:0]  pcOut;
    logic        pcClr;
    logic        pcUp;
    logic        irLd;
    logic [15:0] irOut;
    logic [15:0] romData;

    logic        puReset;
    logic        puClr;
    logic        puUp;
    logic [6:0]  puPc;
    logic        irUnitLd;
    logic [15:0] irUnitD;
    logic [15:0] irUnitQ;

    int nChecks = 0;
    int nPass   = 0;

    CycleRec expQ[$];
    logic [15:0] romImg [0:8];
    logic [6:0]  modelPrevPc;
    bit          modelHavePrev;

    control_unit dut (
        .clk        (clk),
        .reset      (reset),
        .OutState   (outState),
        .NextState  (nextState),
        .D_addr     (dAddr),
        .D_wr       (dWr),
        .RF_s       (rfS),
        .RF_W_en    (rfWEn),
        .RF_Ra_addr (raAddr),
        .RF_Rb_addr (rbAddr),
        .RF_W_addr  (wAddr),
        .ALU_s0     (aluS0),
        .PC_Out     (pcOut),
        .PC_clr     (pcClr),
        .PC_up      (pcUp),
        .IR_ld      (irLd),
        .IR_Out     (irOut),
        .data       (romData)
    );

    ProgramCounter pcUnit (
        .i_clk   (clk),
        .i_reset (puReset),
        .i_clr   (puClr),
        .i_up    (puUp),
        .o_pc    (puPc)
    );

    InstructionRegister irUnit (
        .i_clk   (clk),
        .i_reset (puReset),
        .i_ld    (irUnitLd),
        .i_d     (irUnitD),
        .o_q     (irUnitQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [15:0] romAt(input logic [6:0] a);
        return (a < 7'd9) ? romImg[a] : 16'h0000;
    endfunction

    function automatic CycleRec sampleDut();
        CycleRec r;
        r.st = outState;  r.nx = nextState; r.pc = pcOut;  r.ir = irOut;
        r.dat = romData;  r.dAddr = dAddr;  r.dWr = dWr;   r.rfS = rfS;
        r.rfWEn = rfWEn;  r.ra = raAddr;    r.rb = rbAddr; r.wa = wAddr;
        r.alu = aluS0;    r.pcClr = pcClr;  r.pcUp = pcUp; r.irLd = irLd;
        return r;
    endfunction

    // ROM data seen in a cycle is the word at the PC of the cycle before.
    task automatic pushRec(input CycleRec r);
        CycleRec q;
        q = r;
        q.dat = modelHavePrev ? romAt(modelPrevPc) : 16'h0000;
        modelPrevPc = q.pc;
        modelHavePrev = 1'b1;
        expQ.push_back(q);
    endtask

    // Instruction-level model of the whole program from reset release.
    task automatic buildExpected(input int haltCycles);
        CycleRec r;
        logic [6:0]  pc;
        logic [15:0] ir;
        logic [15:0] w;
        logic [3:0]  ex [$];
        expQ.delete();
        modelHavePrev = 1'b0;
        modelPrevPc = '0;
        pc = '0;
        ir = '0;
        r = '0; r.st = 4'd0; r.nx = 4'd1; r.pcClr = 1'b1;
        pushRec(r);
        for (int k = 0; k < 9; k++) begin
            w = romImg[k];
            r = '0; r.st = 4'd1; r.nx = 4'd2; r.pc = pc; r.ir = ir; r.pcUp = 1'b1; r.irLd = 1'b1;
            pushRec(r);
            pc = pc + 7'd1;
            ir = w;
            ex.delete();
            case (w[15:12])
                4'd1: ex.push_back(4'd6);
                4'd2: begin ex.push_back(4'd4); ex.push_back(4'd5); end
                4'd3: ex.push_back(4'd7);
                4'd4: ex.push_back(4'd8);
                4'd5: for (int h = 0; h < haltCycles; h++) ex.push_back(4'd9);
                default: ex.push_back(4'd3);
            endcase
            r = '0; r.st = 4'd2; r.nx = ex[0]; r.pc = pc; r.ir = ir;
            pushRec(r);
            for (int e = 0; e < ex.size(); e++) begin
                r = '0; r.st = ex[e]; r.pc = pc; r.ir = ir;
                r.nx = (ex[e] == 4'd4) ? 4'd5 : (ex[e] == 4'd9) ? 4'd9 : 4'd1;
                case (ex[e])
                    4'd4: begin r.dAddr = w[11:4]; r.wa = w[3:0]; r.rfS = 1'b1; end
                    4'd5: begin r.dAddr = w[11:4]; r.wa = w[3:0]; r.rfS = 1'b1; r.rfWEn = 1'b1; end
                    4'd6: begin r.dAddr = w[11:4]; r.ra = w[3:0]; r.dWr = 1'b1; end
                    4'd7: begin r.ra = w[11:8]; r.rb = w[7:4]; r.wa = w[3:0]; r.alu = 3'b001; r.rfWEn = 1'b1; end
                    4'd8: begin r.ra = w[11:8]; r.rb = w[7:4]; r.wa = w[3:0]; r.alu = 3'b010; r.rfWEn = 1'b1; end
                    default: ;
                endcase
                pushRec(r);
            end
        end
    endtask

    // Release reset at a falling edge and compare cycles 0..lastCycle.
    task automatic runProgram(input string name, input int lastCycle);
        CycleRec act;
        CycleRec exp;
        buildExpected(8);
        @(negedge clk);
        reset = 1'b0;
        #1;
        for (int c = 0; c <= lastCycle; c++) begin
            if (c > 0) @(negedge clk);
            nChecks++;
            if (expQ.size() == 0) begin
                $display("[TB] FAIL %s cycle %0d: got no expected entry, want one", name, c);
            end else begin
                exp = expQ.pop_front();
                act = sampleDut();
                if (act !== exp)
                    $display("[TB] FAIL %s cycle %0d: got %h, want %h", name, c, act, exp);
                else
                    nPass++;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        nChecks++;
        if ({outState, nextState, pcOut, irOut, romData} !== {4'd0, 4'd1, 7'd0, 16'h0, 16'h0})
            $display("[TB] FAIL reset_state: got st=%0d nx=%0d pc=%0d ir=%h data=%h, want 0 1 0 0000 0000",
                     outState, nextState, pcOut, irOut, romData);
        else nPass++;
        nChecks++;
        if ({pcClr, pcUp, irLd, dWr, rfWEn, rfS, aluS0} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000})
            $display("[TB] FAIL reset_strobes: got %b%b%b%b%b%b%b, want 100000000",
                     pcClr, pcUp, irLd, dWr, rfWEn, rfS, aluS0);
        else nPass++;
    endtask

    task automatic test_first_load();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        nChecks++;
        if ({outState, nextState, pcClr} !== {4'd0, 4'd1, 1'b1})
            $display("[TB] FAIL first_c0: got st=%0d nx=%0d clr=%b, want 0 1 1", outState, nextState, pcClr);
        else nPass++;
        @(negedge clk);
        nChecks++;
        if ({outState, irLd, pcUp} !== {4'd1, 1'b1, 1'b1})
            $display("[TB] FAIL first_c1: got st=%0d ld=%b up=%b, want 1 1 1", outState, irLd, pcUp);
        else nPass++;
        @(negedge clk);
        nChecks++;
        if ({irOut, pcOut} !== {16'h20B1, 7'd1})
            $display("[TB] FAIL first_c2: got ir=%h pc=%0d, want 20b1 1", irOut, pcOut);
        else nPass++;
        @(negedge clk);
        nChecks++;
        if ({outState, dAddr, wAddr, rfS, rfWEn} !== {4'd4, 8'h0B, 4'd1, 1'b1, 1'b0})
            $display("[TB] FAIL first_c3: got st=%0d da=%h w=%0d s=%b we=%b, want 4 0b 1 1 0",
                     outState, dAddr, wAddr, rfS, rfWEn);
        else nPass++;
        @(negedge clk);
        nChecks++;
        if ({outState, rfWEn, nextState} !== {4'd5, 1'b1, 4'd1})
            $display("[TB] FAIL first_c4: got st=%0d we=%b nx=%0d, want 5 1 1", outState, rfWEn, nextState);
        else nPass++;
        reset = 1'b1;
    endtask

    task automatic test_program();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        runProgram("program", 34);
        nChecks++;
        if ({outState, pcOut} !== {4'd9, 7'd9})
            $display("[TB] FAIL halt_hold: got st=%0d pc=%0d, want 9 9", outState, pcOut);
        else nPass++;
        reset = 1'b1;
    endtask

    task automatic test_reset_abort(input string name, input int abortCycle);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        runProgram(name, abortCycle);
        #2;
        reset = 1'b1;
        #1;
        nChecks++;
        if ({outState, dWr, rfWEn, pcOut, irOut, romData} !== {4'd0, 1'b0, 1'b0, 7'd0, 16'h0, 16'h0})
            $display("[TB] FAIL %s_abort: got st=%0d wr=%b we=%b pc=%0d ir=%h data=%h, want 0 0 0 0 0000 0000",
                     name, outState, dWr, rfWEn, pcOut, irOut, romData);
        else nPass++;
        repeat (2) @(posedge clk);
        runProgram({name, "_rerun"}, 34);
        reset = 1'b1;
    endtask

    task automatic test_pc_unit();
        int expPc;
        puReset = 1'b1; puClr = 1'b0; puUp = 1'b0;
        @(negedge clk);
        puReset = 1'b0;
        puUp = 1'b1;
        expPc = 0;
        for (int i = 0; i < 133; i++) begin
            @(negedge clk);
            expPc = (expPc + 1) % 128;
            if (i >= 125) begin
                nChecks++;
                if (puPc !== 7'(expPc))
                    $display("[TB] FAIL pc_count step %0d: got %0d, want %0d", i, puPc, expPc);
                else nPass++;
            end
        end
        puClr = 1'b1;
        @(negedge clk);
        nChecks++;
        if (puPc !== 7'd0) $display("[TB] FAIL pc_clr_priority: got %0d, want 0", puPc);
        else nPass++;
        puClr = 1'b0;
        repeat (3) @(negedge clk);
        puUp = 1'b0;
        repeat (2) @(negedge clk);
        nChecks++;
        if (puPc !== 7'd3) $display("[TB] FAIL pc_hold: got %0d, want 3", puPc);
        else nPass++;
    endtask

    task automatic test_ir_unit();
        irUnitLd = 1'b1; irUnitD = 16'hA5A5;
        @(negedge clk);
        nChecks++;
        if (irUnitQ !== 16'hA5A5) $display("[TB] FAIL ir_load: got %h, want a5a5", irUnitQ);
        else nPass++;
        irUnitLd = 1'b0; irUnitD = 16'h1234;
        repeat (2) @(negedge clk);
        nChecks++;
        if (irUnitQ !== 16'hA5A5) $display("[TB] FAIL ir_hold: got %h, want a5a5", irUnitQ);
        else nPass++;
        irUnitLd = 1'b1;
        @(negedge clk);
        nChecks++;
        if (irUnitQ !== 16'h1234) $display("[TB] FAIL ir_reload: got %h, want 1234", irUnitQ);
        else nPass++;
    endtask

    initial begin
        romImg[0] = 16'h20B1; romImg[1] = 16'h21B2; romImg[2] = 16'h2063;
        romImg[3] = 16'h28A4; romImg[4] = 16'h4145; romImg[5] = 16'h4326;
        romImg[6] = 16'h3560; romImg[7] = 16'h1CD0; romImg[8] = 16'h5000;
        reset = 1'b1;
        puReset = 1'b1; puClr = 1'b0; puUp = 1'b0;
        irUnitLd = 1'b0; irUnitD = '0;
        test_reset();
        test_first_load();
        test_program();
        test_reset_abort("store", 28);
        test_reset_abort("halt", 32);
        test_pc_unit();
        test_ir_unit();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
